// File: rtl/wb_spram_pkg.sv
// Shared constants and helpers for the Wishbone single-port RAM.
// Latency: none (package only).
// Backpressure: not applicable.
package wb_spram_pkg;

   localparam int WB_DW   = 32;
   localparam int WB_SELW = 4;

   // Expand a byte-select vector into a bit mask covering the selected lanes
   function automatic logic [WB_DW-1:0] sel_to_mask(input logic [WB_SELW-1:0] sel);
      logic [WB_DW-1:0] mask;
      mask = '0;
      for (int n = 0; n < WB_SELW; n++) begin
         mask[8*n +: 8] = {8{sel[n]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/spram_core.sv
// Plain synchronous word array with per-bit write mask and registered read port.
// Latency: read data valid one cycle after enable; writes land on the same edge.
// Backpressure: none, accepts one access per cycle.
module spram_core
   import wb_spram_pkg::*;
#(
   parameter int AW = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en_i,
   input  logic                we_i,
   input  logic [AW-3:0]       idx_i,
   input  logic [WB_DW-1:0]    mask_i,
   input  logic [WB_DW-1:0]    wdat_i,
   output logic [WB_DW-1:0]    rdat_o
);

   localparam int WORDS = 1 << (AW - 2);

   // Storage is deliberately not reset so preloaded contents survive rst_n
   logic [WB_DW-1:0] mem [0:WORDS-1];
   logic [WB_DW-1:0] rdat_q;
   logic [WB_DW-1:0] rdat_d;

   // Masked write: unselected lanes keep their old contents
   always_ff @(posedge clk) begin
      if (en_i && we_i) begin
         mem[idx_i] <= (mem[idx_i] & ~mask_i) | (wdat_i & mask_i);
      end
   end

   // Read register updates only on a read, otherwise holds its last value
   always_comb begin
      rdat_d = rdat_q;
      if (en_i && !we_i) begin
         rdat_d = mem[idx_i];
      end
   end

   // Read data register, cleared by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdat_q <= '0;
      end else begin
         rdat_q <= rdat_d;
      end
   end

   assign rdat_o = rdat_q;

endmodule

// File: rtl/wb_spramx32.sv
// Wishbone B4 pipelined slave wrapping a 32-bit single-port RAM.
// Latency: ack/err one cycle after acceptance; stall is never asserted.
// Optional macro WB_SPRAM_RANGE_CHECK_EN: out-of-range addresses get wb_err instead of aliasing.
module wb_spramx32
   import wb_spram_pkg::*;
#(
   parameter int SIZE = 'h10000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wb_cyc,
   input  logic                  wb_stb,
   input  logic                  wb_we,
   input  logic [31:0]           wb_adr,
   input  logic [WB_SELW-1:0]    wb_sel,
   input  logic [WB_DW-1:0]      wb_dat_i,
   output logic [WB_DW-1:0]      wb_dat_o,
   output logic                  wb_ack,
   output logic                  wb_stall,
   output logic                  wb_err
);

   localparam int AW = $clog2(SIZE);

   logic accept;
   logic out_of_range;
   logic mem_en;
   logic ack_q, ack_d;
   logic err_q, err_d;

   assign accept = wb_cyc & wb_stb;

`ifdef WB_SPRAM_RANGE_CHECK_EN
   // Any address bit at or above AW marks the request as outside the array
   assign out_of_range = (wb_adr >> AW) != 32'd0;
`else
   // High address bits are ignored so accesses wrap modulo SIZE
   assign out_of_range = 1'b0;
`endif

   // Byte-lane bits and (when aliasing) high bits do not reach the array
   logic unused_adr;
   assign unused_adr = ^{wb_adr[1:0], wb_adr[31:AW]};

   // Rejected requests must neither write nor disturb the read register
   assign mem_en = accept & ~out_of_range;

   spram_core #(
      .AW (AW)
   ) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (mem_en),
      .we_i   (wb_we),
      .idx_i  (wb_adr[AW-1:2]),
      .mask_i (sel_to_mask(wb_sel)),
      .wdat_i (wb_dat_i),
      .rdat_o (wb_dat_o)
   );

   // Exactly one of ack/err answers each accepted request
   always_comb begin
      ack_d = accept & ~out_of_range;
      err_d = accept &  out_of_range;
   end

   // Response registers; reset drops any response still pending
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         ack_q <= ack_d;
         err_q <= err_d;
      end
   end

   assign wb_ack   = ack_q;
   assign wb_err   = err_q;
   assign wb_stall = 1'b0;

endmodule

// File: tb/tb_wb_spramx32.sv
module tb_wb_spramx32;

   logic        clk;
   logic        rst_n;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_we;
   logic [31:0] wb_adr;
   logic [3:0]  wb_sel;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack;
   logic        wb_stall;
   logic        wb_err;

   int checks = 0;
   int errors = 0;

   wb_spramx32 #(.SIZE('h10000)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wb_cyc   (wb_cyc),
      .wb_stb   (wb_stb),
      .wb_we    (wb_we),
      .wb_adr   (wb_adr),
      .wb_sel   (wb_sel),
      .wb_dat_i (wb_dat_i),
      .wb_dat_o (wb_dat_o),
      .wb_ack   (wb_ack),
      .wb_stall (wb_stall),
      .wb_err   (wb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one bus cycle's inputs, then step to 1 time unit past the edge
   task automatic bus(input logic cyc, input logic stb, input logic we,
                      input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
      wb_cyc   = cyc;
      wb_stb   = stb;
      wb_we    = we;
      wb_adr   = adr;
      wb_sel   = sel;
      wb_dat_i = dat;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = 0; wb_sel = 0; wb_dat_i = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", wb_ack); end
      checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", wb_err); end
      checks++; if (wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got %h want 00000000", wb_dat_o); end
      checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", wb_stall); end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Array contents are loaded through the bus itself
   task automatic preload();
      bus(1'b1, 1'b1, 1'b1, 32'h0, 4'hF, 32'h00000013);
      bus(1'b1, 1'b1, 1'b1, 32'h4, 4'hF, 32'hDEADBEEF);
      idle();
   endtask

   task automatic test_back_to_back();
      bus(1'b1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
      checks++; if (wb_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1 got %b want 1", wb_ack); end
      checks++; if (wb_dat_o !== 32'h00000013) begin errors++; $display("FAIL b2b_dat1 got %h want 00000013", wb_dat_o); end
      checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall1 got %b want 0", wb_stall); end
      bus(1'b1, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
      checks++; if (wb_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack2 got %b want 1", wb_ack); end
      checks++; if (wb_dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_dat2 got %h want deadbeef", wb_dat_o); end
      checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall2 got %b want 0", wb_stall); end
      idle();
      checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL b2b_idle_ack got %b want 0", wb_ack); end
      checks++; if (wb_dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_hold got %h want deadbeef", wb_dat_o); end
   endtask

   task automatic test_byte_sel();
      bus(1'b1, 1'b1, 1'b1, 32'h8, 4'b1111, 32'h11223344);
      checks++; if (wb_ack !== 1'b1) begin errors++; $display("FAIL sel_wr_ack got %b want 1", wb_ack); end
      bus(1'b1, 1'b1, 1'b1, 32'h8, 4'b0101, 32'hAABBCCDD);
      bus(1'b1, 1'b1, 1'b0, 32'h8, 4'b0000, 32'h0);
      checks++; if (wb_dat_o !== 32'h11BB33DD) begin errors++; $display("FAIL sel_merge got %h want 11bb33dd", wb_dat_o); end
      idle();
   endtask

   task automatic test_raw();
      bus(1'b1, 1'b1, 1'b1, 32'h10, 4'hF, 32'hCAFEF00D);
      bus(1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
      checks++; if (wb_ack !== 1'b1) begin errors++; $display("FAIL raw_ack got %b want 1", wb_ack); end
      checks++; if (wb_dat_o !== 32'hCAFEF00D) begin errors++; $display("FAIL raw_dat got %h want cafef00d", wb_dat_o); end
      idle();
   endtask

   task automatic test_alias();
      bus(1'b1, 1'b1, 1'b0, 32'h10004, 4'hF, 32'h0);
`ifdef WB_SPRAM_RANGE_CHECK_EN
      checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL range_err got %b want 1", wb_err); end
      checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL range_ack got %b want 0", wb_ack); end
      checks++; if (wb_dat_o !== 32'hCAFEF00D) begin errors++; $display("FAIL range_hold got %h want cafef00d", wb_dat_o); end
      // An out-of-range write must not alias onto word 1
      bus(1'b1, 1'b1, 1'b1, 32'h10004, 4'hF, 32'h55555555);
      checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL range_wr_err got %b want 1", wb_err); end
      bus(1'b1, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
      checks++; if (wb_dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL range_mem got %h want deadbeef", wb_dat_o); end
`else
      checks++; if (wb_ack !== 1'b1) begin errors++; $display("FAIL alias_ack got %b want 1", wb_ack); end
      checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL alias_err got %b want 0", wb_err); end
      checks++; if (wb_dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL alias_dat got %h want deadbeef", wb_dat_o); end
`endif
      idle();
   endtask

   task automatic test_reset_pending();
      bus(1'b1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
      checks++; if (wb_ack !== 1'b1) begin errors++; $display("FAIL pend_ack got %b want 1", wb_ack); end
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      rst_n  = 1'b0;
      #1;
      checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_ack got %b want 0", wb_ack); end
      checks++; if (wb_dat_o !== 32'h0) begin errors++; $display("FAIL rst_mid_dat got %h want 00000000", wb_dat_o); end
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus(1'b1, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
      checks++; if (wb_dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_keep_mem got %h want deadbeef", wb_dat_o); end
      idle();
   endtask

   task automatic test_abort();
      bus(1'b0, 1'b1, 1'b1, 32'h0, 4'hF, 32'hFFFFFFFF);
      checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL abort_ack got %b want 0", wb_ack); end
      bus(1'b1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
      checks++; if (wb_dat_o !== 32'h00000013) begin errors++; $display("FAIL abort_mem got %h want 00000013", wb_dat_o); end
      // Dropping cyc right after acceptance still shows the registered ack once
      bus(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 32'h0);
      checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL abort_late_ack got %b want 0", wb_ack); end
   endtask

   task automatic test_sel_zero();
      bus(1'b1, 1'b1, 1'b1, 32'h4, 4'b0000, 32'h00000000);
      checks++; if (wb_ack !== 1'b1) begin errors++; $display("FAIL sel0_ack got %b want 1", wb_ack); end
      bus(1'b1, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
      checks++; if (wb_dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL sel0_mem got %h want deadbeef", wb_dat_o); end
      idle();
      checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL sel0_idle_ack got %b want 0", wb_ack); end
   endtask

   initial begin
      test_reset();
      preload();
      test_back_to_back();
      test_byte_sel();
      test_raw();
      test_alias();
      test_reset_pending();
      test_abort();
      test_sel_zero();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_spramx32.md
Name: wb_spramx32

Overview:
- Single-port 32-bit synchronous RAM with a Wishbone B4 pipelined slave interface.
- Serves both Ibex instruction fetches and data accesses through the shared-bus interconnect. It is the main program/data memory of the ibex_wb system.
- Contents are preloaded by simulation through the word array `mem`. Writes use per-byte select.

Parameters:
- SIZE, 'h10000: memory size in bytes. Must be a power of two and at least 4. The array holds SIZE/4 words.
- AW, log2(SIZE), derived (localparam): number of significant byte-address bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- wb_cyc  in  1  bus cycle active
- wb_stb  in  1  request strobe
- wb_we  in  1  1 = write, 0 = read
- wb_adr  in  32  byte address; bits [1:0] ignored
- wb_sel  in  4  byte enables; bit n selects bits [8n+7:8n]
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_ack  out  1  transfer acknowledge
- wb_stall  out  1  pipeline stall
- wb_err  out  1  error acknowledge

Behaviour:
- Storage: array `mem[0:SIZE/4-1]` of 32-bit words, word-indexed by wb_adr[AW-1:2]. Little-endian byte lanes. Array is not reset; it is preloaded with $readmemh, one word per line.
- Acceptance:
  - A request is accepted on any rising edge with wb_cyc & wb_stb.
  - wb_stall is constantly 0, so one request can be accepted per cycle and back-to-back pipelined requests are supported.
- Write: on acceptance with wb_we=1, update each byte lane whose wb_sel bit is 1; other lanes are unchanged. wb_sel=0 writes nothing but is still acknowledged.
- Read:
  - On acceptance with wb_we=0, wb_dat_o is registered with mem[index] on the same edge. All 4 lanes are returned regardless of wb_sel.
  - Read-after-write to the same address in the next cycle returns the new data (write-first ordering across cycles).
- Ack timing:
  - wb_ack is registered: it equals wb_cyc & wb_stb from the previous edge. Latency is exactly 1 cycle.
  - Exactly one ack per accepted request.
  - Continuous strobing gives an ack every cycle.
- Abort: if wb_cyc is low, no request is accepted. An ack already registered is still driven for that one cycle, and the master ignores it.
- Idle: wb_dat_o holds its last read value when there is no read.
- Address aliasing (feature off): bits above AW-1 are ignored, so the address wraps modulo SIZE.
- Reset (async assert, synchronous deassert handled externally):
  - wb_ack=0, wb_err=0, wb_dat_o=0.
  - Reset mid-transfer drops the pending ack.
  - Memory contents are preserved through reset.

Optional Feature:
- Macro WB_SPRAM_RANGE_CHECK_EN.
- Defined:
  - An accepted request with any wb_adr[31:AW] bit set is answered with wb_err=1 (registered, 1-cycle latency) instead of wb_ack.
  - The write is suppressed and wb_dat_o is not updated.
  - wb_ack and wb_err are never both 1.
- Undefined: wb_err is tied to 0 and out-of-range addresses alias (wrap).

Decomposition:
- Package wb_spram_pkg: constants WB_DW=32, WB_SELW=4, and a function computing the byte-lane write mask from wb_sel.
- One natural sub-module, spram_core: a plain synchronous word array with per-byte write enable and registered read port. It contains `mem`.
- The Wishbone slave logic (ack/err generation) stays in wb_spramx32.

Test Plan:
- Preload mem[0]=32'h00000013, mem[1]=32'hDEADBEEF. Read adr 0 then adr 4 back-to-back:
  - acks in cycles 1 and 2;
  - dat_o = 32'h00000013 then 32'hDEADBEEF;
  - wb_stall=0 throughout.
- Write adr 8, dat 32'h11223344, sel 4'b1111, then write adr 8, dat 32'hAABBCCDD, sel 4'b0101. Read adr 8 -> 32'h11BB33DD.
- Write adr 'h10 = 32'hCAFEF00D, then read adr 'h10 in the immediately following cycle -> 32'hCAFEF00D with one-cycle ack.
- Without the macro, read adr 'h10004 with SIZE='h10000 -> returns mem[1]. With WB_SPRAM_RANGE_CHECK_EN defined -> wb_err=1, wb_ack=0, memory unchanged.
- Assert rst_n=0 while a read is pending -> wb_ack=0 and wb_dat_o=0 immediately. Preloaded mem[1] is still 32'hDEADBEEF after release.
- Strobe with wb_cyc=0 -> no ack and no memory change. Strobe with wb_cyc=1, wb_sel=0, write -> ack asserted and word unchanged.
